lcd_char_receiver: RTL and testbench
====================================

Name: lcd_char_receiver

Overview:
Behavioural and synthesizable HD44780-style character-LCD responder, the receiving end of the 4-bit LCD bus driven by the board display driver (LCDRS/LCDRW/LCDE/LCDDAT).
- Decodes the power-up init sequence, nibble pairs, commands and data writes into a 2x16 character buffer.
- Models the busy flag.
- Used in simulation and on-chip self-check to read back what the CPU status screen actually printed.

Parameters:
BUSY_CYCLES, 40, clk cycles busy after any completed command/data byte except clear/home
CLEAR_CYCLES, 1600, clk cycles busy after clear display or return home; must be >= 32

Ports:
clk  input  1  system clock (CCLK domain); all bus inputs synchronous to it
rst  input  1  asynchronous, active-high reset
lcd_rs  input  1  register select: 0 command, 1 data
lcd_rw  input  1  0 write, 1 read
lcd_e  input  1  enable strobe; bus sampled on its falling edge
lcd_dat  input  4  data nibble DB7..DB4
lcd_dout  output  4  read nibble returned while lcd_rw=1
rd_idx  input  5  buffer index {line, column[3:0]}
rd_char  output  8  buffer character at rd_idx, registered
busy  output  1  busy flag
four_bit  output  1  4-bit mode reached
display_on  output  1  D bit of last display-control command
cursor_addr  output  7  address counter (AC)
byte_strobe  output  1  one-cycle pulse when a byte or 8-bit-mode command completes
byte_val  output  9  {rs, byte} of last completed byte
proto_err  output  1  sticky: write while busy, or CGRAM access

Behaviour:
Reset values (async):
- lcd_dout=0, rd_char=0, busy=0, four_bit=0, display_on=0, cursor_addr=0, byte_strobe=0, byte_val=0, proto_err=0.
- Nibble phase=HIGH; increment mode=1.
- Buffer filled with 0x20 over the first 32 cycles after reset release; busy=1 during that fill.

Strobe detection:
- lcd_e registered once; a falling edge is e_q=1 and lcd_e=0.
- All bus fields are sampled in that same cycle.

8-bit phase (four_bit=0):
- Each falling edge forms byte {lcd_dat,4'h0}.
- Only function-set commands (upper nibble 0x2 or 0x3) are acted on; others are ignored.
- A 0x2 nibble sets four_bit=1 and pulses byte_strobe.
- Busy checking is suppressed in this phase.

4-bit phase:
- First write edge latches the high nibble; second edge completes the byte.
- The phase toggles only on write edges.
- A completed byte pulses byte_strobe for one cycle. byte_val updates in the same cycle.

Completed command bytes, decoded by highest set bit:
- 0x01 clear: fill 0x20 one entry per cycle (32 cycles); AC=0; increment=1; busy=CLEAR_CYCLES.
- 0x02/0x03 home: AC=0; busy=CLEAR_CYCLES.
- 0x04-0x07 entry mode: increment=bit1.
- 0x08-0x0F display control: display_on=bit2.
- 0x10-0x1F shift: bit3=0 moves the cursor (bit2 gives direction, with the same wrap rules as data writes); bit3=1 is ignored.
- 0x20-0x3F function set: ignored.
- 0x40-0x7F CGRAM address: proto_err=1.
- 0x80-0xFF: AC=byte[6:0].

Completed data bytes (rs=1):
- Store to buffer index {AC[6],AC[3:0]} only if AC[5:4]==0, i.e. columns 0x00-0x0F and 0x40-0x4F.
- AC then steps by +1 or -1.

AC wrap:
- Increment: 0x27 -> 0x40, 0x67 -> 0x00.
- Decrement: 0x00 -> 0x67, 0x40 -> 0x27.

Busy:
- Loads its count on byte completion and decrements to 0; busy=(count!=0).
- In 4-bit mode, a write edge while busy sets proto_err and is discarded. The nibble phase is not toggled.

Reads (lcd_rw=1, rs=0):
- lcd_dout is updated on the rising edge of lcd_e.
- Phase HIGH returns {busy,AC[6:4]}; phase LOW returns AC[3:0].
- Read edges toggle a separate read phase.
- A read with rs=1 returns 0.

Other rules:
- rd_char=buf[rd_idx] with 1-cycle latency.
- A clear in progress and a reset: reset wins immediately.
- A write edge in the same cycle the busy count reaches 0 is accepted.

Test Plan:
1. Reset, then init nibbles 3,3,3,2 with gaps -> four_bit=1 after the 4th edge; 4 byte_strobe pulses; proto_err=0.
2. Init, then 0x80, then data 'P','C' (0x50,0x43) spaced > BUSY_CYCLES -> rd_idx 0 = 0x50, rd_idx 1 = 0x43; cursor_addr=0x02.
3. Init, then 0xC0, then data 'E' -> rd_idx 16 = 0x45; cursor_addr=0x41.
4. Init, then 0x81, then 0x41 with no gap -> second byte high nibble discarded; proto_err=1; rd_idx 1 stays 0x20.
5. AC=0x27, then write 0x41 -> cursor_addr=0x40; no buffer change. Then entry mode 0x04, AC=0x40, write -> rd_idx 16=0x41; cursor_addr=0x27.
6. Fill a char, then 0x01 -> busy held CLEAR_CYCLES cycles; all 32 entries read 0x20; read-pair returns lcd_dout=4'b1000 then 0 mid-clear; mid-clear rst clears busy at once.

Source files
------------

// File: rtl/lcd_char_receiver.sv
// HD44780-style character LCD responder for the 4-bit LCD bus.
// Decodes the init sequence, nibble pairs, commands and data writes into a
// 2x16 character buffer, models the busy flag and answers status reads.
module lcd_char_receiver #(
   parameter int BUSY_CYCLES  = 40,
   parameter int CLEAR_CYCLES = 1600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic       lcd_e,
   input  logic [3:0] lcd_dat,
   output logic [3:0] lcd_dout,
   input  logic [4:0] rd_idx,
   output logic [7:0] rd_char,
   output logic       busy,
   output logic       four_bit,
   output logic       display_on,
   output logic [6:0] cursor_addr,
   output logic       byte_strobe,
   output logic [8:0] byte_val,
   output logic       proto_err
);

   localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES);
   localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic {PH_HIGH, PH_LOW} nib_phase_t;
   typedef enum logic [1:0] {FILL_PEND, FILL_RUN, FILL_IDLE} fill_state_t;

   logic             e_q;
   logic             e_fall;
   logic             e_rise;
   logic             wr_edge;
   logic             wr_blocked;
   logic [7:0]       full_byte;

   nib_phase_t       nib_phase, nib_phase_nx;
   nib_phase_t       rd_phase;
   logic [3:0]       hi_nib, hi_nib_nx;
   logic [6:0]       ac, ac_nx;
   logic             incr, incr_nx;
   logic             four_bit_nx;
   logic             display_on_nx;
   logic             proto_err_nx;
   logic             byte_strobe_nx;
   logic [8:0]       byte_val_nx;
   logic [CNT_W-1:0] busy_cnt, busy_cnt_nx;
   logic             clear_go;
   logic             data_we;

   fill_state_t      fill_state, fill_state_nx;
   logic [4:0]       fill_idx;
   logic [7:0]       char_buf [32];

   // Next address counter value after one cursor step, folding the two
   // 40-column DDRAM lines into one ring (0x00-0x27, then 0x40-0x67).
   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
      logic [6:0] r;
      if (up) begin
         if (a == 7'h27)      r = 7'h40;
         else if (a == 7'h67) r = 7'h00;
         else                 r = a + 7'd1;
      end else begin
         if (a == 7'h00)      r = 7'h67;
         else if (a == 7'h40) r = 7'h27;
         else                 r = a - 7'd1;
      end
      return r;
   endfunction

   assign e_fall      = e_q & ~lcd_e;
   assign e_rise      = ~e_q & lcd_e;
   assign wr_edge     = e_fall & ~lcd_rw;
   assign wr_blocked  = four_bit && (busy_cnt > CNT_ONE);
   assign full_byte   = {hi_nib, lcd_dat};
   assign busy        = (busy_cnt != '0) || (fill_state == FILL_RUN);
   assign cursor_addr = ac;

   // Delay the enable strobe one cycle so its edges can be detected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) e_q <= 1'b0;
      else     e_q <= lcd_e;
   end

   // Decode write edges into nibble pairs, commands, data stores and busy load.
   always_comb begin
      nib_phase_nx   = nib_phase;
      hi_nib_nx      = hi_nib;
      ac_nx          = ac;
      incr_nx        = incr;
      four_bit_nx    = four_bit;
      display_on_nx  = display_on;
      proto_err_nx   = proto_err;
      byte_strobe_nx = 1'b0;
      byte_val_nx    = byte_val;
      busy_cnt_nx    = (busy_cnt != '0) ? busy_cnt - CNT_ONE : busy_cnt;
      clear_go       = 1'b0;
      data_we        = 1'b0;
      if (wr_edge) begin
         if (!four_bit) begin
            if (!lcd_rs && (lcd_dat == 4'h2 || lcd_dat == 4'h3)) begin
               byte_strobe_nx = 1'b1;
               byte_val_nx    = {1'b0, lcd_dat, 4'h0};
               busy_cnt_nx    = BUSY_LOAD;
               if (lcd_dat == 4'h2) four_bit_nx = 1'b1;
            end
         end else if (wr_blocked) begin
            proto_err_nx = 1'b1;
         end else if (nib_phase == PH_HIGH) begin
            hi_nib_nx    = lcd_dat;
            nib_phase_nx = PH_LOW;
         end else begin
            nib_phase_nx   = PH_HIGH;
            byte_strobe_nx = 1'b1;
            byte_val_nx    = {lcd_rs, full_byte};
            busy_cnt_nx    = BUSY_LOAD;
            if (lcd_rs) begin
               data_we = (ac[5:4] == 2'b00);
               ac_nx   = ac_step(ac, incr);
            end else begin
               casez (full_byte)
                  8'b1???????: ac_nx = full_byte[6:0];
                  8'b01??????: proto_err_nx = 1'b1;
                  8'b001?????: begin end
                  8'b0001????: if (!full_byte[3]) ac_nx = ac_step(ac, full_byte[2]);
                  8'b00001???: display_on_nx = full_byte[2];
                  8'b000001??: incr_nx = full_byte[1];
                  8'b0000001?: begin
                     ac_nx       = 7'h00;
                     busy_cnt_nx = CLEAR_LOAD;
                  end
                  8'b00000001: begin
                     clear_go    = 1'b1;
                     ac_nx       = 7'h00;
                     incr_nx     = 1'b1;
                     busy_cnt_nx = CLEAR_LOAD;
                  end
                  default: begin end
               endcase
            end
         end
      end
   end

   // Register the decoded control state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nib_phase   <= PH_HIGH;
         hi_nib      <= 4'h0;
         ac          <= 7'h00;
         incr        <= 1'b1;
         four_bit    <= 1'b0;
         display_on  <= 1'b0;
         proto_err   <= 1'b0;
         byte_strobe <= 1'b0;
         byte_val    <= 9'h000;
         busy_cnt    <= '0;
      end else begin
         nib_phase   <= nib_phase_nx;
         hi_nib      <= hi_nib_nx;
         ac          <= ac_nx;
         incr        <= incr_nx;
         four_bit    <= four_bit_nx;
         display_on  <= display_on_nx;
         proto_err   <= proto_err_nx;
         byte_strobe <= byte_strobe_nx;
         byte_val    <= byte_val_nx;
         busy_cnt    <= busy_cnt_nx;
      end
   end

   // Status reads: present the nibble on the rising strobe, advance the pair on the falling one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lcd_dout <= 4'h0;
         rd_phase <= PH_HIGH;
      end else begin
         if (e_rise && lcd_rw) begin
            if (lcd_rs)                  lcd_dout <= 4'h0;
            else if (rd_phase == PH_HIGH) lcd_dout <= {busy, ac[6:4]};
            else                          lcd_dout <= ac[3:0];
         end
         if (e_fall && lcd_rw)
            rd_phase <= (rd_phase == PH_HIGH) ? PH_LOW : PH_HIGH;
      end
   end

   // Fill sequencer register: blanks the buffer after reset and on clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_state <= FILL_PEND;
         fill_idx   <= 5'd0;
      end else begin
         fill_state <= fill_state_nx;
         if (clear_go)                     fill_idx <= 5'd0;
         else if (fill_state == FILL_RUN)  fill_idx <= fill_idx + 5'd1;
      end
   end

   // Fill sequencer next state: one entry per cycle, 32 cycles, restartable by clear.
   always_comb begin
      fill_state_nx = fill_state;
      case (fill_state)
         FILL_PEND: fill_state_nx = FILL_RUN;
         FILL_RUN:  if (fill_idx == 5'd31) fill_state_nx = FILL_IDLE;
         FILL_IDLE: fill_state_nx = FILL_IDLE;
         default:   fill_state_nx = FILL_IDLE;
      endcase
      if (clear_go) fill_state_nx = FILL_RUN;
   end

   // Character buffer write port; blanking has priority over data stores.
   always_ff @(posedge clk) begin
      if (fill_state == FILL_RUN) char_buf[fill_idx] <= 8'h20;
      else if (data_we)           char_buf[{ac[6], ac[3:0]}] <= full_byte;
   end

   // Registered readback port for the self-check logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_char <= 8'h00;
      else     rd_char <= char_buf[rd_idx];
   end

endmodule

// File: tb/tb_lcd_char_receiver.sv
// Testbench for lcd_char_receiver: directed bus sequences plus randomized
// commands and characters, checked against a display-level reference model.
module tb_lcd_char_receiver;

   localparam int BUSY  = 40;
   localparam int CLEAR = 1600;
   localparam int GAP   = BUSY + 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       lcd_rs = 1'b0;
   logic       lcd_rw = 1'b0;
   logic       lcd_e = 1'b0;
   logic [3:0] lcd_dat = 4'h0;
   logic [3:0] lcd_dout;
   logic [4:0] rd_idx = 5'd0;
   logic [7:0] rd_char;
   logic       busy;
   logic       four_bit;
   logic       display_on;
   logic [6:0] cursor_addr;
   logic       byte_strobe;
   logic [8:0] byte_val;
   logic       proto_err;

   int n_vectors = 0;
   int n_miscompares = 0;
   int strobe_cnt = 0;

   // Reference model: display contents and cursor as a position on an 80-cell ring.
   logic [7:0] m_buf [32];
   int         m_lin;
   logic       m_incr;
   logic       m_disp;
   logic       m_err;
   logic [8:0] m_val;
   int         m_strobes;

   lcd_char_receiver #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLEAR)) dut (
      .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
      .lcd_dat(lcd_dat), .lcd_dout(lcd_dout), .rd_idx(rd_idx), .rd_char(rd_char),
      .busy(busy), .four_bit(four_bit), .display_on(display_on),
      .cursor_addr(cursor_addr), .byte_strobe(byte_strobe), .byte_val(byte_val),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   // Count completed-byte pulses away from the active edge.
   always @(negedge clk) if (byte_strobe) strobe_cnt++;

   function automatic logic [6:0] lin2addr(input int lin);
      if (lin < 40) return 7'(lin);
      return 7'(lin - 40 + 64);
   endfunction

   function automatic int addr2lin(input logic [6:0] a);
      if (a < 7'h40) return int'(a);
      return int'(a) - 64 + 40;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vectors++;
      assert (obs === exp) else begin
         n_miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
   endtask

   // Apply one completed byte to the reference model.
   task automatic model_byte(input logic rs, input logic [7:0] b);
      int col;
      m_val = {rs, b};
      m_strobes++;
      if (rs) begin
         col = m_lin % 40;
         if (col < 16) m_buf[(m_lin / 40) * 16 + col] = b;
         m_lin = (m_lin + (m_incr ? 1 : 79)) % 80;
      end else if (b >= 8'h80) m_lin = addr2lin(b[6:0]);
      else if (b >= 8'h40) m_err = 1'b1;
      else if (b >= 8'h20) begin end
      else if (b >= 8'h10) begin
         if (!b[3]) m_lin = (m_lin + (b[2] ? 1 : 79)) % 80;
      end
      else if (b >= 8'h08) m_disp = b[2];
      else if (b >= 8'h04) m_incr = b[1];
      else if (b >= 8'h02) m_lin = 0;
      else if (b == 8'h01) begin
         model_clear();
         m_lin  = 0;
         m_incr = 1'b1;
      end
   endtask

   task automatic write_nibble(input logic rs, input logic [3:0] n);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = 1'b0; lcd_dat = n; lcd_e = 1'b1;
      @(negedge clk);
      lcd_e = 1'b0;
   endtask

   task automatic write_byte(input logic rs, input logic [7:0] b, input int gap);
      write_nibble(rs, b[7:4]);
      write_nibble(rs, b[3:0]);
      model_byte(rs, b);
      repeat (gap) @(negedge clk);
   endtask

   task automatic read_nibble(input logic rs, output logic [3:0] d);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
      @(negedge clk);
      d = lcd_dout;
      lcd_e = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_char(input int idx, input logic [7:0] exp);
      @(negedge clk);
      rd_idx = 5'(idx);
      @(negedge clk);
      check_output($sformatf("rd_char[%0d]", idx), {24'h0, rd_char}, {24'h0, exp});
   endtask

   task automatic check_state(input string tag);
      check_output({tag, " cursor_addr"}, {25'h0, cursor_addr}, {25'h0, lin2addr(m_lin)});
      check_output({tag, " byte_val"}, {23'h0, byte_val}, {23'h0, m_val});
      check_output({tag, " display_on"}, {31'h0, display_on}, {31'h0, m_disp});
   endtask

   initial begin
      logic [3:0] d0, d1;
      logic [7:0] b;
      int n;
      model_clear();
      m_lin = 0; m_incr = 1'b1; m_disp = 1'b0; m_err = 1'b0; m_val = 9'h0; m_strobes = 0;

      // Reset values while reset is held.
      repeat (3) @(negedge clk);
      check_output("rst lcd_dout", {28'h0, lcd_dout}, 32'h0);
      check_output("rst rd_char", {24'h0, rd_char}, 32'h0);
      check_output("rst busy", {31'h0, busy}, 32'h0);
      check_output("rst four_bit", {31'h0, four_bit}, 32'h0);
      check_output("rst display_on", {31'h0, display_on}, 32'h0);
      check_output("rst cursor_addr", {25'h0, cursor_addr}, 32'h0);
      check_output("rst byte_strobe", {31'h0, byte_strobe}, 32'h0);
      check_output("rst byte_val", {23'h0, byte_val}, 32'h0);
      check_output("rst proto_err", {31'h0, proto_err}, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_output("fill busy", {31'h0, busy}, 32'h1);
      repeat (40) @(negedge clk);
      check_output("fill done busy", {31'h0, busy}, 32'h0);

      // Power-up init: 3,3,3 in 8-bit phase, then 2 enters 4-bit mode.
      for (int i = 0; i < 4; i++) begin
         write_nibble(1'b0, (i == 3) ? 4'h2 : 4'h3);
         m_strobes++;
         repeat (GAP) @(negedge clk);
         check_output($sformatf("init four_bit %0d", i), {31'h0, four_bit}, (i == 3) ? 32'h1 : 32'h0);
      end
      m_val = 9'h020;
      check_output("init strobes", strobe_cnt, m_strobes);
      check_output("init byte_val", {23'h0, byte_val}, {23'h0, m_val});
      check_output("init proto_err", {31'h0, proto_err}, 32'h0);

      write_byte(1'b0, 8'h28, GAP);
      write_byte(1'b0, 8'h0C, GAP);
      write_byte(1'b0, 8'h06, GAP);
      check_state("setup");

      // Line 1 writes, then line 2.
      write_byte(1'b0, 8'h80, GAP);
      write_byte(1'b1, 8'h50, GAP);
      write_byte(1'b1, 8'h43, GAP);
      check_char(0, m_buf[0]);
      check_char(1, m_buf[1]);
      check_state("PC");
      write_byte(1'b0, 8'hC0, GAP);
      write_byte(1'b1, 8'h45, GAP);
      check_char(16, m_buf[16]);
      check_state("E");

      // A byte sent immediately after another is lost while busy.
      write_byte(1'b0, 8'h81, 0);
      write_nibble(1'b1, 4'h4);
      write_nibble(1'b1, 4'h1);
      m_err = 1'b1;
      repeat (GAP) @(negedge clk);
      check_output("nogap proto_err", {31'h0, proto_err}, {31'h0, m_err});
      check_char(1, m_buf[1]);
      check_state("nogap");

      // Wrap at the end of line 1 and backwards from the start of line 2.
      write_byte(1'b0, 8'hA7, GAP);
      write_byte(1'b1, 8'h41, GAP);
      check_state("wrap inc");
      write_byte(1'b0, 8'h04, GAP);
      write_byte(1'b0, 8'hC0, GAP);
      write_byte(1'b1, 8'h41, GAP);
      check_char(16, m_buf[16]);
      check_state("wrap dec");
      write_byte(1'b0, 8'h06, GAP);

      // Randomized mix of address sets, data, shifts, display and entry commands.
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 4))
            0: write_byte(1'b0, {1'b1, lin2addr($urandom_range(0, 79))}, GAP);
            1: write_byte(1'b1, 8'($urandom_range(33, 126)), GAP);
            2: write_byte(1'b0, 8'h10 | 8'($urandom_range(0, 3) << 2), GAP);
            3: write_byte(1'b0, 8'h08 | 8'($urandom_range(0, 7)), GAP);
            default: write_byte(1'b0, 8'h04 | 8'($urandom_range(0, 1) << 1), GAP);
         endcase
         check_state($sformatf("rand %0d", i));
      end
      for (int i = 0; i < 32; i++) check_char(i, m_buf[i]);
      check_output("rand strobes", strobe_cnt, m_strobes);

      // Idle status read pair, then a data-register read pair.
      read_nibble(1'b0, d0);
      read_nibble(1'b0, d1);
      check_output("read hi idle", {28'h0, d0}, {28'h0, 1'b0, lin2addr(m_lin)[6:4]});
      check_output("read lo idle", {28'h0, d1}, {28'h0, lin2addr(m_lin)[3:0]});
      read_nibble(1'b1, d0);
      read_nibble(1'b1, d1);
      check_output("read rs1 a", {28'h0, d0}, 32'h0);
      check_output("read rs1 b", {28'h0, d1}, 32'h0);

      // Clear: busy duration and blanked buffer.
      b = 8'($urandom_range(65, 90));
      write_byte(1'b0, 8'h80, GAP);
      write_byte(1'b1, b, GAP);
      write_byte(1'b0, 8'h01, 0);
      n = 0;
      for (int k = 0; k < 3 * CLEAR; k++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      check_output("clear busy cycles", n, CLEAR);
      for (int i = 0; i < 32; i++) check_char(i, m_buf[i]);
      check_state("clear");

      // Status reads and reset in the middle of a clear.
      write_byte(1'b1, b, GAP);
      write_byte(1'b0, 8'h01, 0);
      repeat (5) @(negedge clk);
      read_nibble(1'b0, d0);
      read_nibble(1'b0, d1);
      check_output("read hi clear", {28'h0, d0}, 32'h8);
      check_output("read lo clear", {28'h0, d1}, 32'h0);
      check_output("mid clear busy", {31'h0, busy}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("rst mid clear busy", {31'h0, busy}, 32'h0);
      check_output("rst mid clear four_bit", {31'h0, four_bit}, 32'h0);
      check_output("rst mid clear proto_err", {31'h0, proto_err}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check_output("post rst busy", {31'h0, busy}, 32'h0);
      check_char(0, 8'h20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
